ram_boot_loader: RTL and testbench



---
 rtl/ram_boot_loader_if.sv | 17 +
 rtl/ram_boot_loader.sv | 136 +++++++++++++
 tb/tb_ram_boot_loader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_boot_loader_if.sv
// Word-stream load channel into ram_boot_loader.
// A word moves when ld_valid and ld_ready are both high at a rising clk edge.
// The master holds ld_addr/ld_data/ld_last stable while ld_valid is high.
// ld_ready depends only on the loader's state and never on ld_valid.
interface ram_boot_loader_if #(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 5
);
  logic                    ld_valid;
  logic                    ld_ready;
  logic [ADDRESS_SIZE-1:0] ld_addr;
  logic [WORD_SIZE-1:0]    ld_data;
  logic                    ld_last;

  modport master (output ld_valid, ld_addr, ld_data, ld_last, input ld_ready);
  modport slave  (input ld_valid, ld_addr, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/ram_boot_loader.sv
// Boot/reload front end that owns the single RAM port.
// It keeps the CPU halted while (address, data) words are streamed into RAM,
// then sequences the CPU reset and enable so the CPU takes over the port.
// The RAM port is a plain state-selected mux, so no bus is ever floated.
module ram_boot_loader #(
  parameter int WORD_SIZE     = 8,
  parameter int ADDRESS_SIZE  = 5,
  parameter bit BOOT_ON_RESET = 1'b1,
  parameter int RESET_CYCLES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  ram_boot_loader_if.slave        ld,
  input  logic                    cpu_w,
  input  logic [ADDRESS_SIZE-1:0] cpu_waddr,
  input  logic [WORD_SIZE-1:0]    cpu_wdata,
  input  logic [ADDRESS_SIZE-1:0] cpu_raddr,
  output logic                    ram_w,
  output logic [ADDRESS_SIZE-1:0] ram_waddr,
  output logic [WORD_SIZE-1:0]    ram_wdata,
  output logic [ADDRESS_SIZE-1:0] ram_raddr,
  output logic                    cpu_en,
  output logic                    cpu_reset,
  output logic                    busy,
  output logic [ADDRESS_SIZE:0]   load_count,
  output logic [WORD_SIZE-1:0]    checksum,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    S_HALT    = 2'd0,
    S_LOAD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  // Release counter only needs to reach RESET_CYCLES-1.
  localparam int REL_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int REL_LAST = RESET_CYCLES - 1;
  // load_count saturates at the RAM depth.
  localparam logic [ADDRESS_SIZE:0] COUNT_MAX = {1'b1, {ADDRESS_SIZE{1'b0}}};

  state_t                  state, state_next;
  logic [REL_W-1:0]        rel_cnt, rel_next;
  logic [ADDRESS_SIZE:0]   count_next;
  logic [WORD_SIZE-1:0]    sum_next;
  logic                    accept;

  // A word is taken only while loading; ld_valid elsewhere is ignored.
  assign accept    = (state == S_LOAD) && ld.ld_valid;
  assign state_dbg = state;

  // State register plus load counters and release counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_HALT;
      rel_cnt    <= '0;
      load_count <= '0;
      checksum   <= '0;
    end else begin
      state      <= state_next;
      rel_cnt    <= rel_next;
      load_count <= count_next;
      checksum   <= sum_next;
    end
  end

  // Next-state logic; counters clear on every edge that enters LOAD.
  always_comb begin
    state_next = state;
    rel_next   = rel_cnt;
    count_next = load_count;
    sum_next   = checksum;
    case (state)
      S_HALT: begin
        if (!BOOT_ON_RESET) begin
          state_next = S_RELEASE;
          rel_next   = '0;
        end else if (load_start) begin
          state_next = S_LOAD;
          count_next = '0;
          sum_next   = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (load_count != COUNT_MAX) count_next = load_count + 1'b1;
          sum_next = checksum + ld.ld_data;
          if (ld.ld_last) begin
            state_next = S_RELEASE;
            rel_next   = '0;
          end
        end
      end
      S_RELEASE: begin
        if (rel_cnt == REL_W'(REL_LAST)) begin
          state_next = S_RUN;
        end else begin
          rel_next = rel_cnt + REL_W'(1);
        end
      end
      S_RUN: begin
        if (load_start) begin
          state_next = S_LOAD;
          count_next = '0;
          sum_next   = '0;
        end
      end
      default: state_next = S_HALT;
    endcase
  end

  // Outputs and RAM port mux decoded from the current state.
  always_comb begin
    ld.ld_ready = (state == S_LOAD);
    busy        = (state == S_LOAD) || (state == S_RELEASE);
    cpu_en      = (state == S_RUN);
    cpu_reset   = (state == S_RUN);
    ram_w       = 1'b0;
    ram_waddr   = cpu_waddr;
    ram_wdata   = cpu_wdata;
    ram_raddr   = cpu_raddr;
    case (state)
      S_LOAD: begin
        ram_w     = ld.ld_valid;
        ram_waddr = ld.ld_addr;
        ram_wdata = ld.ld_data;
        ram_raddr = ld.ld_addr;
      end
      S_RUN:   ram_w = cpu_w;
      default: ram_w = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ram_boot_loader.sv
// Bench for ram_boot_loader: a behavioural RAM, a word-queue reference model
// and one task per scenario.
module tb_ram_boot_loader;
  localparam int W     = 8;
  localparam int A     = 5;
  localparam int RC    = 2;
  localparam int DEPTH = 1 << A;
  localparam logic [1:0] ST_HALT = 2'd0;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_start;
  logic         cpu_w;
  logic [A-1:0] cpu_waddr, cpu_raddr;
  logic [W-1:0] cpu_wdata;
  logic         ram_w, cpu_en, cpu_reset, busy;
  logic [A-1:0] ram_waddr, ram_raddr;
  logic [W-1:0] ram_wdata, checksum;
  logic [A:0]   load_count;
  logic [1:0]   state_dbg;

  logic         nb_ram_w, nb_cpu_en, nb_cpu_reset, nb_busy;
  logic [A-1:0] nb_ram_waddr, nb_ram_raddr;
  logic [W-1:0] nb_ram_wdata, nb_checksum;
  logic [A:0]   nb_load_count;
  logic [1:0]   nb_state_dbg;

  ram_boot_loader_if #(.WORD_SIZE(W), .ADDRESS_SIZE(A)) ld_if ();
  ram_boot_loader_if #(.WORD_SIZE(W), .ADDRESS_SIZE(A)) nb_if ();

  ram_boot_loader #(.WORD_SIZE(W), .ADDRESS_SIZE(A), .BOOT_ON_RESET(1'b1), .RESET_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .ld(ld_if.slave),
    .cpu_w(cpu_w), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_raddr(cpu_raddr),
    .ram_w(ram_w), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_raddr(ram_raddr),
    .cpu_en(cpu_en), .cpu_reset(cpu_reset), .busy(busy),
    .load_count(load_count), .checksum(checksum), .state_dbg(state_dbg));

  ram_boot_loader #(.WORD_SIZE(W), .ADDRESS_SIZE(A), .BOOT_ON_RESET(1'b0), .RESET_CYCLES(RC)) dut_nb (
    .clk(clk), .reset(reset), .load_start(1'b0), .ld(nb_if.slave),
    .cpu_w(1'b0), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_raddr(cpu_raddr),
    .ram_w(nb_ram_w), .ram_waddr(nb_ram_waddr), .ram_wdata(nb_ram_wdata), .ram_raddr(nb_ram_raddr),
    .cpu_en(nb_cpu_en), .cpu_reset(nb_cpu_reset), .busy(nb_busy),
    .load_count(nb_load_count), .checksum(nb_checksum), .state_dbg(nb_state_dbg));

  // clock / reset
  always #5 clk = ~clk;

  // behavioural RAM on the shared port
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk) if (ram_w) mem[ram_waddr] <= ram_wdata;

  // reference model: words of the current load plus expected RAM image
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_mem [DEPTH];
  bit           exp_known [DEPTH];
  int checks = 0;
  int errors = 0;

  function automatic int model_count();
    return (exp_q.size() > DEPTH) ? DEPTH : exp_q.size();
  endfunction

  function automatic logic [W-1:0] model_sum();
    logic [W-1:0] s = '0;
    foreach (exp_q[i]) s = s + exp_q[i];
    return s;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_word(input logic [A-1:0] a, input logic [W-1:0] d, input logic last);
    ld_if.ld_valid = 1'b1; ld_if.ld_addr = a; ld_if.ld_data = d; ld_if.ld_last = last;
    tick();
    ld_if.ld_valid = 1'b0; ld_if.ld_last = 1'b0;
    exp_q.push_back(d); exp_mem[a] = d; exp_known[a] = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (state_dbg !== ST_HALT) begin errors++; $display("FAIL reset_state got %0d want %0d", state_dbg, ST_HALT); end
    checks++; if ({cpu_en, cpu_reset, ld_if.ld_ready, busy} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {cpu_en, cpu_reset, ld_if.ld_ready, busy}); end
    checks++; if (load_count !== '0 || checksum !== '0) begin errors++; $display("FAIL reset_counters got %0d/%0h want 0/0", load_count, checksum); end
    reset = 1'b1;
    tick();
    checks++; if (state_dbg !== ST_HALT) begin errors++; $display("FAIL boot_waits_halt got %0d want %0d", state_dbg, ST_HALT); end
    ld_if.ld_valid = 1'b1; ld_if.ld_addr = 5'd3; ld_if.ld_data = 8'h99; #1;
    checks++; if (ram_w !== 1'b0) begin errors++; $display("FAIL halt_ignores_valid got %b want 0", ram_w); end
    ld_if.ld_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [A-1:0] addrs [4] = '{5'd0, 5'd1, 5'd2, 5'd3};
    logic [W-1:0] datas [4] = '{8'h0A, 8'h14, 8'h40, 8'h80};
    start_load();
    checks++; if (ld_if.ld_ready !== 1'b1) begin errors++; $display("FAIL ready_after_start got %b want 1", ld_if.ld_ready); end
    for (int i = 0; i < 4; i++) send_word(addrs[i], datas[i], i == 3);
    checks++; if (ld_if.ld_ready !== 1'b0) begin errors++; $display("FAIL ready_after_last got %b want 0", ld_if.ld_ready); end
    checks++; if (load_count !== (A+1)'(model_count())) begin errors++; $display("FAIL basic_count got %0d want %0d", load_count, model_count()); end
    checks++; if (checksum !== model_sum()) begin errors++; $display("FAIL basic_checksum got %0h want %0h", checksum, model_sum()); end
    for (int k = 0; k < RC; k++) begin
      checks++; if ({cpu_reset, cpu_en} !== 2'b00) begin errors++; $display("FAIL release_hold cycle %0d got %b want 00", k, {cpu_reset, cpu_en}); end
      tick();
    end
    checks++; if ({cpu_reset, cpu_en, busy} !== 3'b110) begin errors++; $display("FAIL basic_run got %b want 110", {cpu_reset, cpu_en, busy}); end
    for (int a = 0; a < DEPTH; a++) if (exp_known[a]) begin
      checks++; if (mem[a] !== exp_mem[a]) begin errors++; $display("FAIL basic_ram[%0d] got %0h want %0h", a, mem[a], exp_mem[a]); end
    end
    // stray stream words in RUN must not reach RAM or counters
    cpu_w = 1'b0;
    ld_if.ld_valid = 1'b1; ld_if.ld_addr = 5'd0; ld_if.ld_data = 8'hEE; #1;
    checks++; if (ram_w !== 1'b0) begin errors++; $display("FAIL run_ignores_valid got %b want 0", ram_w); end
    tick();
    ld_if.ld_valid = 1'b0;
    checks++; if (load_count !== (A+1)'(model_count())) begin errors++; $display("FAIL run_count_stable got %0d want %0d", load_count, model_count()); end
  endtask

  task automatic test_gaps();
    logic v;
    logic [A-1:0] a;
    logic [W-1:0] d;
    start_load();
    for (int i = 0; i <= 8; i++) begin
      v = (i % 2 == 0);
      a = A'($urandom_range(0, DEPTH - 1));
      d = W'($urandom_range(0, 255));
      ld_if.ld_valid = v; ld_if.ld_addr = a; ld_if.ld_data = d; ld_if.ld_last = (i == 8);
      load_start = (i == 4);
      #1;
      checks++; if (ram_w !== v) begin errors++; $display("FAIL gap_ram_w cycle %0d got %b want %b", i, ram_w, v); end
      tick();
      load_start = 1'b0;
      if (v) begin exp_q.push_back(d); exp_mem[a] = d; exp_known[a] = 1'b1; end
      checks++; if (load_count !== (A+1)'(model_count())) begin errors++; $display("FAIL gap_count cycle %0d got %0d want %0d", i, load_count, model_count()); end
    end
    ld_if.ld_valid = 1'b0; ld_if.ld_last = 1'b0;
    checks++; if (checksum !== model_sum()) begin errors++; $display("FAIL gap_checksum got %0h want %0h", checksum, model_sum()); end
    repeat (RC) tick();
    checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL gap_run got %b want 1", cpu_en); end
    for (int j = 0; j < DEPTH; j++) if (exp_known[j]) begin
      checks++; if (mem[j] !== exp_mem[j]) begin errors++; $display("FAIL gap_ram[%0d] got %0h want %0h", j, mem[j], exp_mem[j]); end
    end
  endtask

  task automatic test_preempt();
    cpu_w = 1'b1; cpu_waddr = 5'd10; cpu_wdata = 8'd3; #1;
    checks++; if (ram_w !== 1'b1) begin errors++; $display("FAIL cpu_write_passes got %b want 1", ram_w); end
    tick();
    exp_mem[10] = 8'd3; exp_known[10] = 1'b1;
    checks++; if (mem[10] !== exp_mem[10]) begin errors++; $display("FAIL cpu_write_ram got %0h want %0h", mem[10], exp_mem[10]); end
    start_load();
    checks++; if ({cpu_en, cpu_reset} !== 2'b00) begin errors++; $display("FAIL preempt_cpu got %b want 00", {cpu_en, cpu_reset}); end
    cpu_wdata = 8'h55; #1;
    checks++; if (ram_w !== 1'b0) begin errors++; $display("FAIL preempt_block got %b want 0", ram_w); end
    tick();
    checks++; if (mem[10] !== exp_mem[10]) begin errors++; $display("FAIL preempt_ram got %0h want %0h", mem[10], exp_mem[10]); end
    cpu_w = 1'b0;
    send_word(5'd10, 8'd7, 1'b1);
    checks++; if (mem[10] !== exp_mem[10]) begin errors++; $display("FAIL reload_ram got %0h want %0h", mem[10], exp_mem[10]); end
    checks++; if (load_count !== (A+1)'(model_count())) begin errors++; $display("FAIL reload_count got %0d want %0d", load_count, model_count()); end
    repeat (RC) tick();
    checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL reload_run got %b want 1", cpu_en); end
  endtask

  task automatic test_reset_mid_load();
    start_load();
    send_word(5'd20, W'($urandom_range(0, 255)), 1'b0);
    send_word(5'd21, W'($urandom_range(0, 255)), 1'b0);
    ld_if.ld_valid = 1'b1; ld_if.ld_addr = 5'd22; ld_if.ld_data = W'($urandom_range(0, 255));
    #2 reset = 1'b0;
    #1;
    checks++; if (state_dbg !== ST_HALT) begin errors++; $display("FAIL midreset_state got %0d want %0d", state_dbg, ST_HALT); end
    checks++; if ({cpu_en, cpu_reset, ld_if.ld_ready, busy, ram_w} !== 5'b00000) begin errors++; $display("FAIL midreset_ctrl got %b want 00000", {cpu_en, cpu_reset, ld_if.ld_ready, busy, ram_w}); end
    checks++; if (load_count !== '0 || checksum !== '0) begin errors++; $display("FAIL midreset_counters got %0d/%0h want 0/0", load_count, checksum); end
    ld_if.ld_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    for (int a = 20; a <= 21; a++) begin
      checks++; if (mem[a] !== exp_mem[a]) begin errors++; $display("FAIL midreset_ram[%0d] got %0h want %0h", a, mem[a], exp_mem[a]); end
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] d;
    // start and valid together in HALT: transition only
    load_start = 1'b1;
    ld_if.ld_valid = 1'b1; ld_if.ld_addr = 5'd20; ld_if.ld_data = ~exp_mem[20]; #1;
    checks++; if (ram_w !== 1'b0) begin errors++; $display("FAIL start_valid_ram_w got %b want 0", ram_w); end
    tick();
    load_start = 1'b0; ld_if.ld_valid = 1'b0;
    exp_q.delete();
    checks++; if (mem[20] !== exp_mem[20]) begin errors++; $display("FAIL start_valid_ram got %0h want %0h", mem[20], exp_mem[20]); end
    checks++; if (ld_if.ld_ready !== 1'b1) begin errors++; $display("FAIL start_valid_ready got %b want 1", ld_if.ld_ready); end
    d = '0;
    for (int i = 0; i <= DEPTH; i++) begin
      d = W'($urandom_range(0, 255));
      send_word(A'(i % DEPTH), d, i == DEPTH);
    end
    checks++; if (load_count !== (A+1)'(model_count())) begin errors++; $display("FAIL sat_count got %0d want %0d", load_count, model_count()); end
    checks++; if (checksum !== model_sum()) begin errors++; $display("FAIL sat_checksum got %0h want %0h", checksum, model_sum()); end
    checks++; if (mem[0] !== d) begin errors++; $display("FAIL sat_overwrite got %0h want %0h", mem[0], d); end
    for (int a = 0; a < DEPTH; a++) begin
      checks++; if (mem[a] !== exp_mem[a]) begin errors++; $display("FAIL sat_ram[%0d] got %0h want %0h", a, mem[a], exp_mem[a]); end
    end
    repeat (RC) tick();
    checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL sat_run got %b want 1", cpu_en); end
  endtask

  task automatic test_no_boot();
    logic exp_en;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (nb_cpu_en !== 1'b0) begin errors++; $display("FAIL noboot_edge0 got %b want 0", nb_cpu_en); end
    for (int k = 1; k <= RC + 2; k++) begin
      tick();
      exp_en = (k >= RC + 1);
      checks++; if (nb_cpu_en !== exp_en) begin errors++; $display("FAIL noboot_edge%0d got %b want %b", k, nb_cpu_en, exp_en); end
    end
    checks++; if (nb_load_count !== '0) begin errors++; $display("FAIL noboot_count got %0d want 0", nb_load_count); end
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < DEPTH; a++) begin exp_known[a] = 1'b0; exp_mem[a] = '0; end
    reset = 1'b0; load_start = 1'b0;
    cpu_w = 1'b0; cpu_waddr = '0; cpu_wdata = '0; cpu_raddr = '0;
    ld_if.ld_valid = 1'b0; ld_if.ld_addr = '0; ld_if.ld_data = '0; ld_if.ld_last = 1'b0;
    nb_if.ld_valid = 1'b0; nb_if.ld_addr = '0; nb_if.ld_data = '0; nb_if.ld_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_gaps();
    test_preempt();
    test_reset_mid_load();
    test_saturation();
    test_no_boot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
